// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider (DIV/DIVU); result {rem, quo} for HI/LO.
// Latency: ready pulses 33 cycles after the start capture; 1 cycle for divide-by-zero.
// Backpressure: none; execute holds start and stalls; dropping start or annul aborts.
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] rem_fix;
  logic [31:0] quo_fix;

  // Operand magnitudes; 0x80000000 maps to itself and is then treated as unsigned.
  always_comb begin
    abs_a = (signed_div && srca[31]) ? (32'd0 - srca) : srca;
    abs_b = (signed_div && srcb[31]) ? (32'd0 - srcb) : srcb;
  end

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor in 33 bits.
  always_comb begin
    rem_sh = {rem, quo[31]};
    diff   = rem_sh - {1'b0, dvsr};
    if (!diff[32]) begin
      rem_nx = diff[31:0];
      quo_nx = {quo[30:0], 1'b1};
    end else begin
      rem_nx = rem_sh[31:0];
      quo_nx = {quo[30:0], 1'b0};
    end
    rem_fix = neg_r ? (32'd0 - rem_nx) : rem_nx;
    quo_fix = neg_q ? (32'd0 - quo_nx) : quo_nx;
  end

  // Control FSM and datapath registers; annul outranks every other transition.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      cnt    <= 6'd0;
      rem    <= 32'd0;
      quo    <= 32'd0;
      dvsr   <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= 64'd0;
      ready  <= 1'b0;
      busy   <= 1'b0;
    end else if (annul) begin
      state <= S_IDLE;
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (srcb == 32'd0) begin
              // Divide by zero: raw dividend to HI, all-ones to LO, no sign fix.
              result <= {srca, 32'hFFFF_FFFF};
              ready  <= 1'b1;
              state  <= S_DONE;
            end else begin
              neg_q <= signed_div & (srca[31] ^ srcb[31]);
              neg_r <= signed_div & srca[31];
              quo   <= abs_a;
              rem   <= 32'd0;
              dvsr  <= abs_b;
              cnt   <= 6'd0;
              state <= S_BUSY;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_BUSY: begin
          if (!start) begin
            // Execute withdrew the request (flush or instruction change).
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              result <= {rem_fix, quo_fix};
              ready  <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // start is not looked at here; execute may drop it combinationally.
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard queue of expected results.
// Inputs driven and outputs sampled on the falling edge.
// Covers directed cases, abort/annul/reset, back-to-back and random operands.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  bit scramble = 0;

  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [63:0] mon_e;
  string       mon_t;

  div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .srca       (srca),
    .srcb       (srcb),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Golden model, written independently of the shift/subtract datapath.
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sd) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  // Scoreboard: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready) begin
      if (exp_q.size() == 0) begin
        check("ready_unexpected", {63'd0, ready}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        check({mon_t, "_result"}, result, mon_e);
      end
    end
  end

  // Issue one divide at the next falling edge (C0) and hold start until ready.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] want, input int want_lat);
    int lat;
    bit seen;
    @(negedge clk);
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
    start      = 1'b1;
    signed_div = sd;
    srca       = a;
    srcb       = b;
    exp_q.push_back(want);
    tag_q.push_back(tag);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (ready) begin
        seen = 1;
      end else if (scramble) begin
        srca       = $urandom;
        srcb       = $urandom;
        signed_div = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(want_lat));
    if (!seen && exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      void'(tag_q.pop_back());
    end
  endtask

  logic [31:0] ra;
  logic [31:0] rb;
  logic        rs;
  logic [63:0] last;

  initial begin
    resetn     = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    srca       = 32'd0;
    srcb       = 32'd0;
    annul      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", result, 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    resetn = 1'b1;

    // Directed cases
    run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33);
    run_div("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 33);
    run_div("dbz", 1'b1, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 1);
    repeat (3) @(negedge clk);
    check("result_hold", result, {32'h1234_5678, 32'hFFFF_FFFF});

    // Abort by dropping start at C10, re-issue at C12
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; srca = 32'd100; srcb = 32'd7;
    repeat (10) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'd0, busy}, 64'd0);
    run_div("reissue", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

    // Abort by annul at C20; result must stay as it was
    last = {32'd2, 32'd14};
    @(negedge clk);
    start = 1'b1; signed_div = 1'b1; srca = 32'd55; srcb = 32'd5;
    repeat (20) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    check("annul_busy", {63'd0, busy}, 64'd0);
    check("annul_result", result, last);
    annul = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);
    run_div("post_annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

    // Synchronous reset at C15 clears result; no ready afterwards
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; srca = 32'd9; srcb = 32'd4;
    repeat (15) @(negedge clk);
    resetn = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    check("mid_rst_result", result, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_ready", {63'd0, ready}, 64'd0);
    resetn = 1'b1;
    repeat (40) @(negedge clk);

    // Back-to-back: second issue lands on C34 of the first
    run_div("b2b_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
    run_div("b2b_2", 1'b1, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);

    // Random operands, scrambled after capture
    scramble = 1;
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 50);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 20);
        3:       rb = 32'd0 - 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_div("rand", rs, ra, rb, model(rs, ra, rb), (rb == 32'd0) ? 1 : 33);
    end
    scramble = 0;

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
